rx_command_dispatcher: RTL and testbench

Consumes complete messages from the UART controller's receive side (`rx_message_out` / `rx_header_out` with valid/ready) and routes them by header opcode.
- Key loads are latched into a key register.
- Encrypt/decrypt data blocks go to a one-entry output register for the crypto core.
- Malformed or premature messages are dropped and counted.

Its `in_ready_out` drives the controller's `ext_rx_ready_in`, so backpressure here is what triggers the controller's stall signalling to the host.

---
 rtl/rx_command_dispatcher_if.sv | 28 ++
 rtl/rx_command_dispatcher.sv | 156 +++++++++++++++
 tb/tb_rx_command_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_command_dispatcher_if.sv
// Receive-side message bus and crypto-core data bus of the command dispatcher.
// Both channels use valid/ready: a transfer happens on a rising clock edge where valid and
// ready are both high; once raised, valid and its payload hold steady until that edge.
interface rx_command_dispatcher_if #(
   parameter int MESSAGE_SIZE = 512,
   parameter int HEADER_SIZE  = 32
);
   logic                    in_valid_in;
   logic                    in_ready_out;
   logic [MESSAGE_SIZE-1:0] in_message_in;
   logic [HEADER_SIZE-1:0]  in_header_in;

   logic                    data_valid_out;
   logic                    data_ready_in;
   logic [MESSAGE_SIZE-1:0] data_out;
   logic                    data_encrypt_out;
   logic [15:0]             data_seq_out;

   modport slave (
      input  in_valid_in, in_message_in, in_header_in, data_ready_in,
      output in_ready_out, data_valid_out, data_out, data_encrypt_out, data_seq_out
   );

   modport master (
      output in_valid_in, in_message_in, in_header_in, data_ready_in,
      input  in_ready_out, data_valid_out, data_out, data_encrypt_out, data_seq_out
   );
endinterface

// File: rtl/rx_command_dispatcher.sv
// Routes received messages by header opcode: key loads, one-entry data block register, drops.
// Optional sequence checking is enabled by defining RX_DISPATCHER_SEQ_CHECK_EN.
module rx_command_dispatcher #(
   parameter int MESSAGE_SIZE = 512,
   parameter int HEADER_SIZE  = 32,
   parameter int KEY_SIZE     = 256
) (
   input  logic                clk_in,
   input  logic                rst_in,
   rx_command_dispatcher_if.slave bus,
   output logic [KEY_SIZE-1:0] key_out,
   output logic                key_valid_out,
   output logic                key_loaded_out,
   output logic [7:0]          drop_count_out,
   output logic [7:0]          seq_err_count_out,
   output logic                state_dbg
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam logic [1:0] OP_DATA_DEC = 2'b00;
   localparam logic [1:0] OP_DATA_ENC = 2'b01;
   localparam logic [1:0] OP_KEY_LOAD = 2'b10;
   localparam logic [1:0] OP_RESERVED = 2'b11;

   state_t      state;
   state_t      state_next;

   logic [1:0]  hdr_opcode;
   logic [1:0]  hdr_flow;
   logic [15:0] hdr_seq;
   logic        accept;
   logic        drop;
   logic        take_msg;
   logic        load_key;
   logic        load_data;
   logic        handshake;
   logic        unused_hdr_bits;

   assign hdr_opcode      = bus.in_header_in[1:0];
   assign hdr_flow        = bus.in_header_in[15:14];
   assign hdr_seq         = bus.in_header_in[31:16];
   assign unused_hdr_bits = ^bus.in_header_in[13:2];

   assign state_dbg = state;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      bus.in_ready_out = 1'b0;
      accept           = 1'b0;
      drop             = 1'b0;
      take_msg         = 1'b0;
      load_key         = 1'b0;
      load_data        = 1'b0;
      handshake        = 1'b0;

      case (state)
         IDLE: begin
            bus.in_ready_out = 1'b1;
            accept           = bus.in_valid_in;
            // Data needs a key first; flow-control bits must never arrive from the host.
            drop = accept &&
                   ((hdr_opcode == OP_RESERVED) || (hdr_flow != 2'b00) ||
                    (((hdr_opcode == OP_DATA_DEC) || (hdr_opcode == OP_DATA_ENC)) &&
                     !key_loaded_out));
            take_msg  = accept && !drop;
            load_key  = take_msg && (hdr_opcode == OP_KEY_LOAD);
            load_data = take_msg && ((hdr_opcode == OP_DATA_DEC) || (hdr_opcode == OP_DATA_ENC));
            if (load_data) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            handshake = bus.data_ready_in;
            if (handshake) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         key_out        <= '0;
         key_valid_out  <= 1'b0;
         key_loaded_out <= 1'b0;
      end else begin
         key_valid_out <= load_key;
         if (load_key) begin
            key_out        <= bus.in_message_in[KEY_SIZE-1:0];
            key_loaded_out <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         bus.data_valid_out   <= 1'b0;
         bus.data_out         <= '0;
         bus.data_encrypt_out <= 1'b0;
         bus.data_seq_out     <= '0;
      end else if (load_data) begin
         bus.data_valid_out   <= 1'b1;
         bus.data_out         <= bus.in_message_in;
         bus.data_encrypt_out <= hdr_opcode[0];
         bus.data_seq_out     <= hdr_seq;
      end else if (handshake) begin
         bus.data_valid_out <= 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         drop_count_out <= '0;
      end else if (drop && (drop_count_out != 8'hFF)) begin
         drop_count_out <= drop_count_out + 8'd1;
      end
   end

`ifdef RX_DISPATCHER_SEQ_CHECK_EN
   logic [15:0] expected_seq;
   logic [7:0]  seq_err_count;

   // Dropped messages never advance the expected sequence number.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         expected_seq  <= '0;
         seq_err_count <= '0;
      end else if (take_msg) begin
         if ((hdr_seq != expected_seq) && (seq_err_count != 8'hFF)) begin
            seq_err_count <= seq_err_count + 8'd1;
         end
         expected_seq <= hdr_seq + 16'd1;
      end
   end

   assign seq_err_count_out = seq_err_count;
`else
   assign seq_err_count_out = 8'd0;
`endif

endmodule

// File: tb/tb_rx_command_dispatcher.sv
// Randomized and directed bench for rx_command_dispatcher against a queue-based reference model.
module tb_rx_command_dispatcher;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [255:0] key_out;
   logic         key_valid;
   logic         key_loaded;
   logic [7:0]   drop_count;
   logic [7:0]   seq_err_count;
   logic         state_dbg;

   int checks = 0;
   int errors = 0;
   bit live = 0;
   bit rand_ready = 0;

   rx_command_dispatcher_if #(.MESSAGE_SIZE(512), .HEADER_SIZE(32)) bus ();

   rx_command_dispatcher #(.MESSAGE_SIZE(512), .HEADER_SIZE(32), .KEY_SIZE(256)) dut (
      .clk_in            (clk),
      .rst_in            (rst),
      .bus               (bus),
      .key_out           (key_out),
      .key_valid_out     (key_valid),
      .key_loaded_out    (key_loaded),
      .drop_count_out    (drop_count),
      .seq_err_count_out (seq_err_count),
      .state_dbg         (state_dbg)
   );

   always #5 clk = ~clk;

   // Reference model: pending blocks as {seq, encrypt, payload} in a queue.
   logic [528:0] exp_q[$];
   logic [255:0] m_key;
   logic         m_key_loaded;
   logic         m_key_pulse;
   int           m_drop;
   int           m_seqerr;
   logic [15:0]  m_exp_seq;

   task automatic model_step();
      logic [31:0] hdr;
      logic [1:0]  op;
      bit          ready;
      if (rst) begin
         exp_q.delete();
         m_key        = '0;
         m_key_loaded = 1'b0;
         m_key_pulse  = 1'b0;
         m_drop       = 0;
         m_seqerr     = 0;
         m_exp_seq    = 16'h0000;
         live         = 1;
      end else begin
         ready       = (exp_q.size() == 0);
         m_key_pulse = 1'b0;
         if (!ready && bus.data_ready_in) void'(exp_q.pop_front());
         if (ready && bus.in_valid_in) begin
            hdr = bus.in_header_in;
            op  = hdr[1:0];
            if (op == 2'd3 || hdr[15:14] != 2'd0 || (op != 2'd2 && !m_key_loaded)) begin
               if (m_drop < 255) m_drop = m_drop + 1;
            end else begin
`ifdef RX_DISPATCHER_SEQ_CHECK_EN
               if (hdr[31:16] != m_exp_seq && m_seqerr < 255) m_seqerr = m_seqerr + 1;
               m_exp_seq = hdr[31:16] + 16'd1;
`endif
               if (op == 2'd2) begin
                  m_key        = bus.in_message_in[255:0];
                  m_key_loaded = 1'b1;
                  m_key_pulse  = 1'b1;
               end else begin
                  exp_q.push_back({hdr[31:16], op[0], bus.in_message_in});
               end
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (live) begin
         chk("cmp_in_ready", bus.in_ready_out, exp_q.size() == 0);
         chk("cmp_data_valid", bus.data_valid_out, exp_q.size() != 0);
         if (exp_q.size() != 0) begin
            chk("cmp_data", bus.data_out, exp_q[0][511:0]);
            chk("cmp_encrypt", bus.data_encrypt_out, exp_q[0][512]);
            chk("cmp_seq", bus.data_seq_out, exp_q[0][528:513]);
         end
         chk("cmp_key", key_out, m_key);
         chk("cmp_key_valid", key_valid, m_key_pulse);
         chk("cmp_key_loaded", key_loaded, m_key_loaded);
         chk("cmp_drop_count", drop_count, m_drop[7:0]);
         chk("cmp_seq_err", seq_err_count, m_seqerr[7:0]);
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (rand_ready) bus.data_ready_in = ($urandom_range(0, 3) != 0);
   endtask

   // Returns at the falling edge right after the accepting rising edge.
   task automatic send_msg(input logic [31:0] hdr, input logic [511:0] msg);
      bit done;
      int budget;
      bus.in_header_in  = hdr;
      bus.in_message_in = msg;
      bus.in_valid_in   = 1'b1;
      done   = 0;
      budget = 0;
      while (!done && budget < 64) begin
         @(posedge clk);
         done = bus.in_ready_out;
         @(negedge clk);
         if (rand_ready) bus.data_ready_in = ($urandom_range(0, 3) != 0);
         budget++;
      end
      bus.in_valid_in = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL accept_timeout act=not_accepted exp=accepted hdr=%0h", hdr);
      end
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      bus.in_valid_in    = 1'b0;
      bus.data_ready_in  = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [511:0] rand_msg();
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
      return m;
   endfunction

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog act=running exp=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      logic [511:0] a5;
      logic [31:0]  hdr;
      logic [1:0]   op;
      logic [1:0]   fc;
      logic [15:0]  seq;
      logic [15:0]  seq_ctr;
      int           r;

      bus.in_valid_in   = 1'b0;
      bus.in_header_in  = '0;
      bus.in_message_in = '0;
      bus.data_ready_in = 1'b0;
      a5 = {16{32'hA5A5A5A5}};

      do_reset();
      chk("rst_in_ready", bus.in_ready_out, 1);
      chk("rst_data_valid", bus.data_valid_out, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_key_out", key_out, 0);
      chk("rst_key_loaded", key_loaded, 0);
      chk("rst_drop", drop_count, 0);

      send_msg(32'h0000_0001, rand_msg());
      chk("nokey_drop", drop_count, 1);
      chk("nokey_valid", bus.data_valid_out, 0);
      chk("nokey_ready", bus.in_ready_out, 1);

      send_msg(32'h0000_0002, a5);
      chk("key_pulse", key_valid, 1);
      chk("key_value", key_out, a5[255:0]);
      chk("key_loaded", key_loaded, 1);
      @(negedge clk);
      chk("key_pulse_end", key_valid, 0);

      send_msg(32'h0001_0000, a5 ^ {16{32'h1234_5678}});
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", bus.data_valid_out, 1);
         chk("hold_enc", bus.data_encrypt_out, 0);
         chk("hold_seq", bus.data_seq_out, 1);
         chk("hold_ready", bus.in_ready_out, 0);
         @(negedge clk);
      end
      bus.data_ready_in = 1'b1;
      @(negedge clk);
      chk("release_ready", bus.in_ready_out, 1);
      chk("release_valid", bus.data_valid_out, 0);
      bus.data_ready_in = 1'b0;

      send_msg(32'h0000_8000, rand_msg());
      send_msg(32'h0000_0003, rand_msg());
      chk("fc_res_drop", drop_count, 3);

      bus.data_ready_in = 1'b1;
      send_msg(32'h0002_0001, rand_msg());
      send_msg(32'h0003_0001, rand_msg());
      send_msg(32'h0005_0001, rand_msg());
`ifdef RX_DISPATCHER_SEQ_CHECK_EN
      chk("seq_gap", seq_err_count, 1);
`else
      chk("seq_gap", seq_err_count, 0);
`endif
      send_msg(32'hFFFF_0001, rand_msg());
      send_msg(32'h0000_0001, rand_msg());
`ifdef RX_DISPATCHER_SEQ_CHECK_EN
      chk("seq_wrap", seq_err_count, 2);
`else
      chk("seq_wrap", seq_err_count, 0);
`endif
      tick();
      bus.data_ready_in = 1'b0;
      tick();

      send_msg(32'h0001_0000, rand_msg());
      chk("pre_rst_valid", bus.data_valid_out, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", bus.data_valid_out, 0);
      chk("mid_rst_key_loaded", key_loaded, 0);
      chk("mid_rst_key", key_out, 0);
      chk("mid_rst_drop", drop_count, 0);
      chk("mid_rst_seq_err", seq_err_count, 0);
      chk("mid_rst_ready", bus.in_ready_out, 1);
      rst = 1'b0;

      for (int i = 0; i < 260; i++) send_msg(32'h0000_0003, rand_msg());
      chk("drop_saturate", drop_count, 255);
      do_reset();

      rand_ready = 1;
      seq_ctr    = 16'h0000;
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 15)      op = 2'd2;
         else if (r < 20) op = 2'd3;
         else             op = 2'($urandom_range(0, 1));
         fc = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         r = $urandom_range(0, 19);
         if (r == 0)      seq = 16'($urandom);
         else if (r == 1) seq = 16'hFFFF;
         else             seq = seq_ctr;
         seq_ctr = seq + 16'd1;
         hdr = {seq, fc, 12'($urandom), op};
         send_msg(hdr, rand_msg());
         repeat ($urandom_range(0, 2)) tick();
         if (n == 300) do_reset();
      end

      rand_ready        = 0;
      bus.data_ready_in = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
      chk("drain_empty", bus.data_valid_out, 0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
